sw_pe_affine: RTL
=================

Name: sw_pe_affine

Overview:
- Parametrised next-generation Smith-Waterman systolic processing element with full Gotoh affine-gap scoring.
- Keeps separate H (M), vertical-gap (I) and horizontal-gap (D) matrices.
- Each PE holds one locally latched query symbol, processes one target symbol per cycle, and forwards target, scores, enable and the running best score and its column to its right neighbour.
- Fixes correct highest-score propagation along the chain, adds saturation and best-column tracking.

Parameters:
- SCORE_WIDTH, 12, score width in bits; scores are biased by ZERO.
- BASE_WIDTH, 2, symbol width (2 = nucleotide, 5 = amino acid).
- COL_WIDTH, 10, width of the column counter and best-column field.
- ZERO, 2**(SCORE_WIDTH-1), biased zero.

Ports:
- clk  in  1  clock.
- rst  in  1  asynchronous reset, active-low.
- query_ld  in  1  latch query_in into the query register.
- query_in  in  BASE_WIDTH  query symbol for this PE.
- en_in  in  1  stream enable from left; high while target symbols are valid.
- data_in  in  BASE_WIDTH  target symbol from left.
- M_in  in  SCORE_WIDTH  H(i-1,j) from left.
- I_in  in  SCORE_WIDTH  I(i-1,j) from left.
- High_in  in  SCORE_WIDTH  best score of upstream PEs.
- High_col_in  in  COL_WIDTH  column of High_in.
- match, mismatch, gap_open, gap_extend  in  SCORE_WIDTH each  unsigned penalty magnitudes.
- data_out  out  BASE_WIDTH  registered data_in.
- M_out  out  SCORE_WIDTH  H(i,j).
- I_out  out  SCORE_WIDTH  I(i,j).
- High_out  out  SCORE_WIDTH  max(upstream best, own best).
- High_col_out  out  COL_WIDTH  column of High_out.
- en_out  out  1  registered en_in.
- vld  out  1  one-cycle pulse: High_out/High_col_out are final.

Behaviour:
- Reset (rst=0, async):
  - data_out=0, en_out=0, vld=0, High_col_out=0.
  - M_out, I_out and High_out = ZERO.
  - Internal: state=IDLE, query=0, col=0, own_high=ZERO, own_col=0, M_diag=ZERO, I_diag=ZERO, D=0 (most negative).
- States: IDLE, CALC.
  - IDLE --en_in=1--> CALC.
  - CALC --en_in=0--> IDLE.
- query_ld: honoured only in IDLE; ignored in CALC.
- Every cycle with en_in=1 (IDLE or CALC) computes cell j=col+1, registers all outputs, and sets col<=col+1.
  - col saturates at 2**COL_WIDTH-1.
  - Latency is 1 cycle per PE for data, en and scores.
- On the IDLE->CALC cycle, the previous-column state is taken as initial values (M_up=ZERO, D=0, M_diag=ZERO), and own_high is reset to ZERO.
- Recurrence, s = (data_in==query) ? +match : -mismatch:
  - I = max(M_in - gap_open - gap_extend, I_in - gap_extend).
  - D = max(M_out - gap_open - gap_extend, D_reg - gap_extend).
  - M = max(ZERO, M_diag + s, I_diag, D), where I_diag is the I value of the diagonal cell.
  - Register M_out<=M, I_out<=I, D_reg<=D, M_diag<=M_in, I_diag<=I_in.
- Arithmetic: SCORE_WIDTH+2 bit signed intermediates; each add/sub result saturates to [0, 2**SCORE_WIDTH-1].
- Own best: if M > own_high then own_high<=M and own_col<=j. Ties keep the earlier column.
- High_out <= (own_high_next > High_in) ? own_high_next : High_in, with High_col_out following the same selection.
  - Ties select High_in (upstream).
- End of stream, first cycle with en_in=0 in CALC:
  - vld<=1 for exactly one cycle; en_out<=0; state<=IDLE; col<=0.
  - High_out and High_col_out hold until the next stream starts.
  - M_diag, I_diag and D_reg return to their initial values.
- In IDLE with en_in=0: en_out=0, vld=0, data_out=0; score outputs hold.
- en_in glitching high for one cycle is a valid 1-symbol stream: vld pulses on the next cycle.
- Reset mid-stream: immediate return to reset values; no vld pulse.

Test Plan:
- Query A (query_ld in IDLE); match=2, mismatch=1, gap_open=3, gap_extend=1; single PE with M_in=I_in=High_in=ZERO, High_col_in=0; stream "A"
  -> M_out=2050 one cycle after en_in; High_out=2050, High_col_out=1; vld pulses on the cycle after en_in falls.
- Same setup, stream "GAG"
  -> M_out sequence 2048, 2050, 2048; High_out=2050, High_col_out=2; single vld pulse.
- Two chained PEs, queries A,A; stream "AA"
  -> PE1 M_out at j=2 = 2052; final High_out=2052, High_col_out=2; PE1 vld one cycle after PE0 vld.
- Tie check: High_in=2050, High_col_in=1 while own best=2050 at col 2
  -> High_out=2050, High_col_out=1.
- Saturation: match=2047, stream of 4 matching symbols
  -> M_out clamps at 4095, no wrap.
- query_ld asserted during CALC -> query unchanged.
- rst low mid-stream -> outputs reset immediately, no vld pulse.

Source files
------------

// File: rtl/sw_pe_affine_if.sv
// sw_pe_affine_if: systolic link carrying target symbol, scores and running best between PEs
interface sw_pe_affine_if #(
  parameter int SCORE_WIDTH = 12,
  parameter int BASE_WIDTH  = 2,
  parameter int COL_WIDTH   = 10
);
  logic                   en;
  logic [BASE_WIDTH-1:0]  data;
  logic [SCORE_WIDTH-1:0] m;
  logic [SCORE_WIDTH-1:0] i;
  logic [SCORE_WIDTH-1:0] high;
  logic [COL_WIDTH-1:0]   high_col;
  logic                   vld;
  modport master (output en, data, m, i, high, high_col, vld);
  modport slave  (input  en, data, m, i, high, high_col, vld);
endinterface

// File: rtl/sw_pe_affine.sv
// sw_pe_affine: Smith-Waterman systolic PE with Gotoh affine gaps, saturation and best-column tracking
module sw_pe_affine #(
  parameter int SCORE_WIDTH = 12,
  parameter int BASE_WIDTH  = 2,
  parameter int COL_WIDTH   = 10,
  parameter logic [SCORE_WIDTH-1:0] ZERO = {1'b1, {(SCORE_WIDTH-1){1'b0}}}
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   query_ld,
  input  logic [BASE_WIDTH-1:0]  query_in,
  input  logic [SCORE_WIDTH-1:0] match,
  input  logic [SCORE_WIDTH-1:0] mismatch,
  input  logic [SCORE_WIDTH-1:0] gap_open,
  input  logic [SCORE_WIDTH-1:0] gap_extend,
  sw_pe_affine_if.slave          up,
  sw_pe_affine_if.master         dn
);
  localparam int W = SCORE_WIDTH + 2;
  localparam logic signed [W-1:0] SMAX = {2'b00, {SCORE_WIDTH{1'b1}}};
  typedef enum logic {IDLE, CALC} state_t;
  typedef logic [SCORE_WIDTH-1:0] score_t;

  // clamp a widened signed result back into the unsigned score range
  function automatic score_t sat(input logic signed [W-1:0] v);
    return v < 0 ? '0 : v > SMAX ? '1 : v[SCORE_WIDTH-1:0];
  endfunction

  function automatic score_t add(input score_t a, input score_t b);
    return sat($signed({2'b00, a}) + $signed({2'b00, b}));
  endfunction

  function automatic score_t sub(input score_t a, input score_t b);
    return sat($signed({2'b00, a}) - $signed({2'b00, b}));
  endfunction

  function automatic score_t max2(input score_t a, input score_t b);
    return a > b ? a : b;
  endfunction

  state_t                state;
  logic [BASE_WIDTH-1:0] query;
  logic [COL_WIDTH-1:0]  col, own_col, j, oc, ocn;
  score_t                own_high, m_diag, i_diag, d_reg;
  score_t                m_up, d_prev, md, id, s_val, i_new, d_new, m_new, oh, ohn;
  logic                  first, upd, take_own;

  // cell recurrence; first cycle of a stream starts from a fresh previous column
  always_comb begin
    first    = state == IDLE;
    m_up     = first ? ZERO : dn.m;
    d_prev   = first ? '0 : d_reg;
    md       = first ? ZERO : m_diag;
    id       = first ? ZERO : i_diag;
    s_val    = up.data == query ? add(md, match) : sub(md, mismatch);
    i_new    = max2(sub(sub(up.m, gap_open), gap_extend), sub(up.i, gap_extend));
    d_new    = max2(sub(sub(m_up, gap_open), gap_extend), sub(d_prev, gap_extend));
    m_new    = max2(max2(ZERO, s_val), max2(id, d_new));
    j        = &col ? col : col + 1'b1;
    oh       = first ? ZERO : own_high;
    oc       = first ? '0 : own_col;
    upd      = m_new > oh;
    ohn      = upd ? m_new : oh;
    ocn      = upd ? j : oc;
    take_own = ohn > up.high;
  end

  // state, per-cell registers and forwarded outputs
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state       <= IDLE;
      query       <= '0;
      col         <= '0;
      own_high    <= ZERO;
      own_col     <= '0;
      m_diag      <= ZERO;
      i_diag      <= ZERO;
      d_reg       <= '0;
      dn.en       <= 1'b0;
      dn.data     <= '0;
      dn.m        <= ZERO;
      dn.i        <= ZERO;
      dn.high     <= ZERO;
      dn.high_col <= '0;
      dn.vld      <= 1'b0;
    end else begin
      dn.en   <= up.en;
      dn.data <= up.en ? up.data : '0;
      dn.vld  <= state == CALC && !up.en;
      if (query_ld && state == IDLE) query <= query_in;
      if (up.en) begin
        state       <= CALC;
        col         <= j;
        dn.m        <= m_new;
        dn.i        <= i_new;
        d_reg       <= d_new;
        m_diag      <= up.m;
        i_diag      <= up.i;
        own_high    <= ohn;
        own_col     <= ocn;
        dn.high     <= take_own ? ohn : up.high;
        dn.high_col <= take_own ? ocn : up.high_col;
      end else begin
        state  <= IDLE;
        col    <= '0;
        m_diag <= ZERO;
        i_diag <= ZERO;
        d_reg  <= '0;
      end
    end
  end
endmodule
